// File: rtl/gpu_cpu2vram_pixel_unpack_if.sv
// Word-in / pixel-pair-out bus of the CPU-to-VRAM pixel unpacker.
// Stats signals exist only when GPU_C2V_STATS_EN is defined.
interface gpu_cpu2vram_pixel_unpack_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 20
);
  logic               start;
  logic [10:0]        width;
  logic [9:0]         height;
  logic               force_mask;
  logic               word_valid;
  logic [2*WIDTH-1:0] word;
  logic               word_ready;
  logic               push0;
  logic [WIDTH-1:0]   data0;
  logic               push1;
  logic [WIDTH-1:0]   data1;
  logic               last;
  logic               accept0;
  // Mirrors accept0 on the FIFO side; the unpacker never looks at it.
  logic               accept1;
  logic               busy;
  logic               done;
`ifdef GPU_C2V_STATS_EN
  logic [CNT_W-1:0]   pix_count;
  logic               stall;
`endif

  modport slave (
    input  start, width, height, force_mask, word_valid, word, accept0,
    output word_ready, push0, data0, push1, data1, last, busy, done
`ifdef GPU_C2V_STATS_EN
    , output pix_count, stall
`endif
  );

  modport master (
    output start, width, height, force_mask, word_valid, word, accept0, accept1,
    input  word_ready, push0, data0, push1, data1, last, busy, done
`ifdef GPU_C2V_STATS_EN
    , input pix_count, stall
`endif
  );
endinterface

// File: rtl/gpu_cpu2vram_pixel_unpack.sv
// Splits GP0 upload words into registered pixel pairs for the CPU->VRAM FIFO.
// Optional pixel/stall statistics are enabled with GPU_C2V_STATS_EN.
module gpu_cpu2vram_pixel_unpack #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  gpu_cpu2vram_pixel_unpack_if.slave      bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic               mask_q;
  logic               out_valid;
  logic               pair_q;
  logic               last_q;
  logic [WIDTH-1:0]   data0_q;
  logic [WIDTH-1:0]   data1_q;

  logic [20:0]        prod;
  logic               word_ready;
  logic               load;
  logic               take;
  logic [WIDTH-1:0]   msb;

  assign prod       = 21'(bus.width) * 21'(bus.height);
  // remaining hits zero once the final word is loaded, which closes the input.
  assign word_ready = (state == XFER) && (remaining != '0) && (!out_valid || bus.accept0);
  assign load       = word_ready && bus.word_valid;
  assign take       = out_valid && bus.accept0;
  assign msb        = {mask_q, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      mask_q    <= 1'b0;
      out_valid <= 1'b0;
      pair_q    <= 1'b0;
      last_q    <= 1'b0;
      data0_q   <= '0;
      data1_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            remaining <= CNT_W'(prod);
            mask_q    <= bus.force_mask;
            state     <= (prod == 21'd0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (load) begin
            out_valid <= 1'b1;
            data0_q   <= bus.word[WIDTH-1:0] | msb;
            if (remaining >= CNT_W'(2)) begin
              data1_q   <= bus.word[2*WIDTH-1:WIDTH] | msb;
              pair_q    <= 1'b1;
              last_q    <= (remaining == CNT_W'(2));
              remaining <= remaining - CNT_W'(2);
            end else begin
              data1_q   <= '0;
              pair_q    <= 1'b0;
              last_q    <= 1'b1;
              remaining <= '0;
            end
          end else if (take) begin
            out_valid <= 1'b0;
            pair_q    <= 1'b0;
            last_q    <= 1'b0;
            if (last_q) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.word_ready = word_ready;
  assign bus.push0      = out_valid;
  assign bus.push1      = out_valid && pair_q;
  assign bus.last       = out_valid && last_q;
  assign bus.data0      = data0_q;
  assign bus.data1      = data1_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

`ifdef GPU_C2V_STATS_EN
  logic [CNT_W-1:0] pix_count;

  always_ff @(posedge clk) begin
    if (rst)
      pix_count <= '0;
    else if (state == IDLE && bus.start)
      pix_count <= '0;
    else if (take)
      pix_count <= pix_count + (pair_q ? CNT_W'(2) : CNT_W'(1));
  end

  assign bus.pix_count = pix_count;
  assign bus.stall     = out_valid && !bus.accept0;
`endif
endmodule
